rr_onehot_encoder: RTL and testbench

- Sequential 8-to-3 encoder. It turns a multi-hot request vector into a stream of 3-bit indices, one index per output handshake.
- Requests accumulate in a pending register. Each set bit is issued exactly once, in round-robin or fixed-priority order.
- The output uses a registered valid/ready handshake.
- It is the encode-side counterpart of the team's 3-to-8 one-hot decoder and feeds index consumers such as register-file select and interrupt-source IDs.

---
 rtl/rr_onehot_encoder.sv | 106 ++++++++++
 tb/tb_rr_onehot_encoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_onehot_encoder.sv
// rtl/rr_onehot_encoder.sv - sequential N-to-log2(N) request encoder with round-robin or fixed-priority issue
module rr_onehot_encoder #(
    parameter int N     = 8,
    parameter int IDX_W = 3,
    parameter bit RR    = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N-1:0]     in,
    input  logic             in_valid,
    output logic [IDX_W-1:0] out,
    output logic [N-1:0]     out_onehot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W:0]   pend_cnt,
    output logic             busy
);

    logic [N-1:0]     pending_q, pending_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] out_q, out_d;
    logic [N-1:0]     onehot_q, onehot_d;
    logic             valid_q, valid_d;

    logic [N-1:0]     cand;
    logic             load;
    logic [IDX_W-1:0] scan_base;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic [N-1:0]     sel_onehot;
    logic [IDX_W:0]   cnt;

    // Candidate set merges held requests with this cycle's input so a fresh bit can issue immediately.
    always_comb begin
        cand = pending_q | (in_valid ? in : '0);
        load = (!valid_q || out_ready) && (cand != '0);
    end

    // Scan the candidates starting at the rotating pointer (or at 0 in fixed-priority mode); first hit wins.
    always_comb begin
        scan_base = (RR != 1'b0) ? ptr_q : '0;
        scan_idx  = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            scan_idx = scan_base + IDX_W'(i);
            if (!sel_found && cand[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
        sel_onehot = {{(N-1){1'b0}}, 1'b1} << sel_idx;
    end

    // Next-state: issue on load, otherwise absorb input into pending and drain the output if consumed.
    always_comb begin
        pending_d = cand;
        ptr_d     = ptr_q;
        out_d     = out_q;
        onehot_d  = onehot_q;
        valid_d   = valid_q;
        if (load) begin
            out_d     = sel_idx;
            onehot_d  = sel_onehot;
            valid_d   = 1'b1;
            ptr_d     = sel_idx + 1'b1;
            pending_d = cand & ~sel_onehot;
        end else if (out_ready) begin
            valid_d  = 1'b0;
            onehot_d = '0;
        end
    end

    // State registers; reset discards everything pending or held.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_q <= '0;
            ptr_q     <= '0;
            out_q     <= '0;
            onehot_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            out_q     <= out_d;
            onehot_q  <= onehot_d;
            valid_q   <= valid_d;
        end
    end

    // Population count of pending requests; the index held on out is not part of pending.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + {{IDX_W{1'b0}}, pending_q[i]};
        end
    end

    assign out        = out_q;
    assign out_onehot = onehot_q;
    assign out_valid  = valid_q;
    assign pend_cnt   = cnt;
    assign busy       = valid_q | (pending_q != '0);

endmodule

// File: tb/tb_rr_onehot_encoder.sv
// tb/tb_rr_onehot_encoder.sv - self-checking bench for rr_onehot_encoder (round-robin and fixed-priority)
module tb_rr_onehot_encoder;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] in_d = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic [2:0] out1, out0;
    logic [7:0] oh1, oh0;
    logic       v1, v0;
    logic [3:0] cnt1, cnt0;
    logic       busy1, busy0;

    int nchk = 0;
    int nerr = 0;

    rr_onehot_encoder #(.N(8), .IDX_W(3), .RR(1'b1)) dut_rr (
        .clk(clk), .resetn(resetn), .in(in_d), .in_valid(in_valid),
        .out(out1), .out_onehot(oh1), .out_valid(v1), .out_ready(out_ready),
        .pend_cnt(cnt1), .busy(busy1)
    );

    rr_onehot_encoder #(.N(8), .IDX_W(3), .RR(1'b0)) dut_fp (
        .clk(clk), .resetn(resetn), .in(in_d), .in_valid(in_valid),
        .out(out0), .out_onehot(oh0), .out_valid(v0), .out_ready(out_ready),
        .pend_cnt(cnt0), .busy(busy0)
    );

    always #5 clk = ~clk;

    // Reference model, index 1 = round-robin, index 0 = fixed priority.
    bit [7:0] m_pend [2];
    int       m_ptr  [2];
    int       m_out  [2];
    bit       m_valid[2];

    task automatic model_reset();
        for (int r = 0; r < 2; r++) begin
            m_pend[r] = '0; m_ptr[r] = 0; m_out[r] = 0; m_valid[r] = 0;
        end
    endtask

    task automatic model_step(input int r);
        bit [7:0] c;
        int start, pick;
        c = m_pend[r] | (in_valid ? in_d : 8'h00);
        pick = -1;
        if ((!m_valid[r] || out_ready) && c != 0) begin
            start = (r == 1) ? m_ptr[r] : 0;
            for (int k = 0; k < 8; k++) begin
                if (pick < 0 && c[(start + k) % 8]) pick = (start + k) % 8;
            end
        end
        if (pick >= 0) begin
            m_out[r]   = pick;
            m_valid[r] = 1;
            m_ptr[r]   = (pick + 1) % 8;
            c[pick]    = 1'b0;
            m_pend[r]  = c;
        end else begin
            m_pend[r] = c;
            if (out_ready) m_valid[r] = 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_oh(input int r);
        return m_valid[r] ? (1 << m_out[r]) : 0;
    endfunction

    task automatic check_model();
        chk("rr.out_valid",  int'(v1),    int'(m_valid[1]));
        chk("rr.out",        int'(out1),  m_out[1]);
        chk("rr.out_onehot", int'(oh1),   exp_oh(1));
        chk("rr.pend_cnt",   int'(cnt1),  $countones(m_pend[1]));
        chk("rr.busy",       int'(busy1), int'(m_valid[1] || m_pend[1] != 0));
        chk("fp.out_valid",  int'(v0),    int'(m_valid[0]));
        chk("fp.out",        int'(out0),  m_out[0]);
        chk("fp.out_onehot", int'(oh0),   exp_oh(0));
        chk("fp.pend_cnt",   int'(cnt0),  $countones(m_pend[0]));
        chk("fp.busy",       int'(busy0), int'(m_valid[0] || m_pend[0] != 0));
    endtask

    // One clock: drive inputs, advance model, take the edge, compare just after it.
    task automatic cycle(input logic [7:0] i, input logic iv, input logic rdy);
        in_d = i; in_valid = iv; out_ready = rdy;
        model_step(1);
        model_step(0);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        resetn = 1'b0; in_d = '0; in_valid = 1'b0; out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    typedef struct {
        logic [7:0] in;
        logic       iv;
        logic       rdy;
        int         e_out;
        logic       e_valid;
        int         e_cnt;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // RR ordering, wrap, backpressure and re-request on the round-robin instance.
        vecs[0]  = '{8'hA5, 1, 1, 0, 1, 3};
        vecs[1]  = '{8'h00, 0, 1, 2, 1, 2};
        vecs[2]  = '{8'h00, 0, 1, 5, 1, 1};
        vecs[3]  = '{8'h00, 0, 1, 7, 1, 0};
        vecs[4]  = '{8'h00, 0, 1, 7, 0, 0};
        vecs[5]  = '{8'h03, 1, 1, 0, 1, 1};
        vecs[6]  = '{8'h00, 0, 1, 1, 1, 0};
        vecs[7]  = '{8'h00, 0, 1, 1, 0, 0};
        vecs[8]  = '{8'h18, 1, 0, 3, 1, 1};
        vecs[9]  = '{8'h00, 0, 0, 3, 1, 1};
        vecs[10] = '{8'h00, 0, 1, 4, 1, 0};
        vecs[11] = '{8'h00, 0, 1, 4, 0, 0};
        vecs[12] = '{8'h04, 1, 0, 2, 1, 0};
        vecs[13] = '{8'h04, 1, 0, 2, 1, 1};
        vecs[14] = '{8'h00, 0, 1, 2, 1, 0};
        vecs[15] = '{8'h00, 0, 1, 2, 0, 0};

        do_reset();
        for (int c = 0; c < 5; c++) begin
            cycle(8'h00, 1'b0, 1'b0);
            chk("idle.out_valid", int'(v1), 0);
            chk("idle.out", int'(out1), 0);
            chk("idle.busy", int'(busy1), 0);
        end

        for (int k = 0; k < 16; k++) begin
            cycle(vecs[k].in, vecs[k].iv, vecs[k].rdy);
            chk($sformatf("vec%0d.out_valid", k), int'(v1), int'(vecs[k].e_valid));
            chk($sformatf("vec%0d.out", k), int'(out1), vecs[k].e_out);
            chk($sformatf("vec%0d.pend_cnt", k), int'(cnt1), vecs[k].e_cnt);
        end

        // Fixed priority: a fresh lower index overtakes a pending higher one.
        do_reset();
        cycle(8'h82, 1'b1, 1'b1);
        chk("fp.seq0", int'(out0), 1);
        cycle(8'h01, 1'b1, 1'b1);
        chk("fp.seq1", int'(out0), 0);
        cycle(8'h00, 1'b0, 1'b1);
        chk("fp.seq2", int'(out0), 7);
        chk("fp.seq2v", int'(v0), 1);
        cycle(8'h00, 1'b0, 1'b1);
        chk("fp.seq3v", int'(v0), 0);

        // Asynchronous reset between edges drops everything immediately.
        do_reset();
        cycle(8'hFF, 1'b1, 1'b1);
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h00, 1'b0, 1'b1);
        chk("ar.third", int'(out1), 2);
        chk("ar.pend_before", int'(cnt1), 5);
        #1;
        resetn = 1'b0;
        model_reset();
        #1;
        chk("ar.out_valid", int'(v1), 0);
        chk("ar.out", int'(out1), 0);
        chk("ar.out_onehot", int'(oh1), 0);
        chk("ar.pend_cnt", int'(cnt1), 0);
        chk("ar.busy", int'(busy1), 0);
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle(8'h00, 1'b0, 1'b1);
            chk("ar.after_v", int'(v1), 0);
            chk("ar.after_cnt", int'(cnt1), 0);
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            logic [7:0] ri;
            logic       riv, rrd;
            ri  = 8'($urandom) & 8'($urandom);
            riv = ($urandom_range(0, 2) == 0);
            rrd = ($urandom_range(0, 3) != 0);
            cycle(ri, riv, rrd);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
